// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the register file write port.
// Accepts writes over valid/ready, queues them in a DEPTH-entry FIFO, and
// drains one entry per cycle into a registered wr_* stage. A combinational
// bypass lets readers see writes that the register file has not latched yet.
module regfile_write_buffer #(
    parameter int N     = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 4,
    parameter int ZR    = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [AW-1:0]                in_addr,
    input  logic [N-1:0]                 in_data,
    input  logic                         wr_stall,
    output logic                         wr_en,
    output logic [AW-1:0]                wr_addr,
    output logic [N-1:0]                 wr_data,
    input  logic [AW-1:0]                rd_addr,
    output logic                         rd_hit,
    output logic [N-1:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [N-1:0]  mem_data [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push;
    logic          pop;

    // Writes to the hard-zero register complete the handshake but are dropped.
    // Pop uses the pre-edge count, so a fresh entry is never popped on the edge
    // that pushes it.
    always_comb begin
        in_ready = (count != CW'(DEPTH));
        push     = in_valid && in_ready && (in_addr != AW'(ZR));
        pop      = (count != '0) && !wr_stall;
    end

    // Entry storage; occupancy is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wptr] <= in_addr;
            mem_data[wptr] <= in_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered register-file write stage; address/data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_addr <= mem_addr[rptr];
                wr_data <= mem_data[rptr];
            end
        end
    end

    // Bypass: the wr_* stage has lowest priority, then FIFO entries oldest to
    // youngest, each later match overriding so the youngest write wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        rd_hit  = 1'b0;
        rd_data = '0;
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_hit  = 1'b1;
            rd_data = wr_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if ((CW'(i) < count) && (mem_addr[idx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = mem_data[idx];
            end
        end
        if (rd_addr == AW'(ZR)) begin
            rd_hit  = 1'b0;
            rd_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer: a scoreboard queue holds the
// writes expected to reach the register file in order.
module tb_regfile_write_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_addr = '0;
    logic [63:0] in_data = '0;
    logic        wr_stall = 1'b0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr = '0;
    logic        rd_hit;
    logic [63:0] rd_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [4:0]  exp_addr [$];
    logic [63:0] exp_data [$];

    regfile_write_buffer #(.N(64), .AW(5), .DEPTH(4), .ZR(31)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wr_stall(wr_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One push attempt per call; the queue records only writes that should retire.
    task automatic push_wr(input logic [4:0] a, input logic [63:0] d, output logic acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        acc      = in_ready;
        if (acc && a != 5'd31) begin
            exp_addr.push_back(a);
            exp_data.push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || count != 0 || wr_en) && n < 60) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(exp_addr.size()), 64'd0);
    endtask

    // Scoreboard: every wr_en cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && wr_en) begin
            if (exp_addr.size() == 0) begin
                check("wr_unexpected", 64'd1, 64'd0);
            end else begin
                check("sb_addr", 64'(wr_addr), 64'(exp_addr.pop_front()));
                check("sb_data", wr_data, exp_data.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_rd_hit", 64'(rd_hit), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 1: single write latency
        push_wr(5'd3, 64'hDEAD, acc);
        check("t1_acc", 64'(acc), 64'd1);
        check("t1_count_after_push", 64'(count), 64'd1);
        check("t1_wr_en_early", 64'(wr_en), 64'd0);
        @(posedge clk); #1;
        check("t1_wr_en", 64'(wr_en), 64'd1);
        check("t1_wr_addr", 64'(wr_addr), 64'd3);
        check("t1_wr_data", wr_data, 64'hDEAD);
        check("t1_count", 64'(count), 64'd0);
        @(posedge clk); #1;
        check("t1_wr_en_drop", 64'(wr_en), 64'd0);
        check("t1_wr_addr_hold", 64'(wr_addr), 64'd3);

        // 2: fill under stall, then drain back-to-back
        wr_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push_wr(5'(i), 64'h100 + 64'(i), acc);
        check("t2_count", 64'(count), 64'd4);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        rd_addr = 5'd7;
        #1;
        check("t2_miss_hit", 64'(rd_hit), 64'd0);
        check("t2_miss_data", rd_data, 64'd0);
        rd_addr = 5'd2;
        #1;
        check("t2_byp_data", rd_data, 64'h102);
        push_wr(5'd5, 64'h999, acc);
        check("t2_fifth_acc", 64'(acc), 64'd0);
        check("t2_count_full", 64'(count), 64'd4);
        @(negedge clk);
        wr_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("t2_seq_en", 64'(wr_en), 64'd1);
            check("t2_seq_addr", 64'(wr_addr), 64'(i));
        end
        @(posedge clk); #1;
        check("t2_end_en", 64'(wr_en), 64'd0);
        wait_drain("t2_drain");

        // 3: duplicate address bypass, youngest wins
        wr_stall = 1'b1;
        push_wr(5'd5, 64'hA, acc);
        push_wr(5'd5, 64'hB, acc);
        rd_addr = 5'd5;
        #1;
        check("t3_hit", 64'(rd_hit), 64'd1);
        check("t3_data", rd_data, 64'hB);
        @(negedge clk);
        wr_stall = 1'b0;
        @(posedge clk); #1;
        check("t3_hit_p1", 64'(rd_hit), 64'd1);
        check("t3_data_p1", rd_data, 64'hB);
        @(posedge clk); #1;
        check("t3_hit_p2", 64'(rd_hit), 64'd1);
        check("t3_data_p2", rd_data, 64'hB);
        @(posedge clk); #1;
        check("t3_hit_gone", 64'(rd_hit), 64'd0);
        check("t3_data_gone", rd_data, 64'd0);
        wait_drain("t3_drain");

        // 4: hard-zero register writes are discarded
        push_wr(5'd31, 64'h1234, acc);
        check("t4_acc", 64'(acc), 64'd1);
        check("t4_count", 64'(count), 64'd0);
        rd_addr = 5'd31;
        #1;
        check("t4_rd_hit", 64'(rd_hit), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("t4_wr_en", 64'(wr_en), 64'd0);

        // 5: streaming with pointer wrap
        for (int i = 0; i < 12; i++) begin
            push_wr(5'(i), 64'($urandom), acc);
            check("t5_acc", 64'(acc), 64'd1);
            check("t5_count_le_depth", 64'(count <= 3'd4), 64'd1);
        end
        wait_drain("t5_drain");

        // 6: async reset mid-drain
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_wr(5'(20 + i), 64'h600 + 64'(i), acc);
        rd_addr = 5'd20;
        @(negedge clk);
        wr_stall = 1'b0;
        @(posedge clk); #1;
        check("t6_pre_count", 64'(count), 64'd3);
        check("t6_pre_wr_en", 64'(wr_en), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_wr_en", 64'(wr_en), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd1);
        check("t6_rd_hit", 64'(rd_hit), 64'd0);
        exp_addr.delete();
        exp_data.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t6_post_wr_en", 64'(wr_en), 64'd0);
        check("t6_post_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
